pipe_control_unit: RTL

Registered decode/control stage for the 5-stage MIPS pipeline. Decodes the IF/ID instruction into the full control bundle and latches it into the ID/EX control register. Owns load-use hazard detection, bubble insertion, branch/jump flush, memory-wait freeze and a halt-drain state machine. Replaces the purely combinational decoder in the pipelined datapath.

---
 rtl/pipe_control_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit
// Registered decode/control stage of the 5-stage MIPS pipeline. It decodes the
// IF/ID instruction into the full control bundle and latches it into the ID/EX
// control register. It also owns load-use hazard detection, bubble insertion,
// branch/jump flush, memory-wait freeze and the halt-drain state machine.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   instr              IF/ID instruction word
//   instr_valid        IF/ID holds a real instruction (0 = decode as bubble)
//   mem_busy           MEM stage waiting on dmem; freezes this stage
//   flush              taken branch/jump resolved downstream; squash ID
//   stall              hold PC and IF/ID this cycle (combinational)
//   ex_*               latched ID/EX control bundle
//   halt               sticky CPU halt
module pipe_control_unit #(
   parameter int unsigned REG_W        = 5,
   parameter bit          HAZARD_EN    = 1'b1,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   input  logic             mem_busy,
   input  logic             flush,
   output logic             stall,
   output logic             ex_valid,
   output logic             ex_regwen,
   output logic             ex_dmemren,
   output logic             ex_dmemwen,
   output logic             ex_alusrc,
   output logic             ex_extop,
   output logic [3:0]       ex_aluop,
   output logic [1:0]       ex_memtoreg,
   output logic [1:0]       ex_pcsel,
   output logic             ex_beq,
   output logic [REG_W-1:0] ex_wsel,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic             halt
);

   typedef enum logic [3:0] {
      ALU_SLL  = 4'b0000,
      ALU_SRL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_SLT  = 4'b1010,
      ALU_SLTU = 4'b1011
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LL    = 6'b110000;
   localparam logic [5:0] OP_SC    = 6'b111000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   typedef struct packed {
      logic             valid;
      logic             regwen;
      logic             dmemren;
      logic             dmemwen;
      logic             alusrc;
      logic             extop;
      aluop_t           aluop;
      logic [1:0]       memtoreg;
      logic [1:0]       pcsel;
      logic             beq;
      logic [REG_W-1:0] wsel;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   function automatic ctrl_t bubble_ctrl();
      ctrl_t c;
      c       = '0;
      c.aluop = ALU_AND;
      return c;
   endfunction

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [REG_W-1:0] rs_idx;
   logic [REG_W-1:0] rt_idx;
   logic [REG_W-1:0] rd_idx;
   logic             unused_shamt;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   assign rs_idx       = REG_W'(instr[25:21]);
   assign rt_idx       = REG_W'(instr[20:16]);
   assign rd_idx       = REG_W'(instr[15:11]);
   assign unused_shamt = ^instr[10:6];

   // ---- stage p0: combinational decode of the IF/ID word ----
   ctrl_t dec_p0;
   logic  rs_used_p0;
   logic  rt_used_p0;
   logic  is_halt_p0;

   always_comb begin
      dec_p0        = bubble_ctrl();
      dec_p0.valid  = 1'b1;
      dec_p0.regwen = 1'b1;
      dec_p0.extop  = 1'b1;
      dec_p0.wsel   = rt_idx;
      dec_p0.rs     = rs_idx;
      dec_p0.rt     = rt_idx;
      rs_used_p0    = 1'b1;
      rt_used_p0    = 1'b0;
      is_halt_p0    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_p0.wsel = rd_idx;
            rt_used_p0  = 1'b1;
            case (funct)
               FN_SLL:          dec_p0.aluop = ALU_SLL;
               FN_SRL:          dec_p0.aluop = ALU_SRL;
               FN_JR: begin
                  dec_p0.regwen = 1'b0;
                  dec_p0.pcsel  = 2'd3;
               end
               FN_ADD, FN_ADDU: dec_p0.aluop = ALU_ADD;
               FN_SUB, FN_SUBU: dec_p0.aluop = ALU_SUB;
               FN_AND:          dec_p0.aluop = ALU_AND;
               FN_OR:           dec_p0.aluop = ALU_OR;
               FN_XOR:          dec_p0.aluop = ALU_XOR;
               FN_NOR:          dec_p0.aluop = ALU_NOR;
               FN_SLT:          dec_p0.aluop = ALU_SLT;
               FN_SLTU:         dec_p0.aluop = ALU_SLTU;
               default:         ;
            endcase
         end
         OP_J: begin
            dec_p0.regwen = 1'b0;
            dec_p0.pcsel  = 2'd2;
            rs_used_p0    = 1'b0;
         end
         OP_JAL: begin
            dec_p0.pcsel    = 2'd2;
            dec_p0.memtoreg = 2'd3;
            dec_p0.wsel     = REG_W'(5'd31);
            rs_used_p0      = 1'b0;
         end
         OP_BEQ, OP_BNE: begin
            dec_p0.regwen = 1'b0;
            dec_p0.aluop  = ALU_SUB;
            dec_p0.pcsel  = 2'd1;
            dec_p0.beq    = (opcode == OP_BEQ);
            rt_used_p0    = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.aluop  = ALU_ADD;
         end
         OP_SLTI: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.aluop  = ALU_SLT;
         end
         OP_SLTIU: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.aluop  = ALU_SLTU;
         end
         // Logical immediates are zero-extended.
         OP_ANDI: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.extop  = 1'b0;
            dec_p0.aluop  = ALU_AND;
         end
         OP_ORI: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.extop  = 1'b0;
            dec_p0.aluop  = ALU_OR;
         end
         OP_XORI: begin
            dec_p0.alusrc = 1'b1;
            dec_p0.extop  = 1'b0;
            dec_p0.aluop  = ALU_XOR;
         end
         OP_LUI: begin
            dec_p0.alusrc   = 1'b1;
            dec_p0.memtoreg = 2'd2;
            rs_used_p0      = 1'b0;
         end
         OP_LW, OP_LL: begin
            dec_p0.alusrc   = 1'b1;
            dec_p0.aluop    = ALU_ADD;
            dec_p0.dmemren  = 1'b1;
            dec_p0.memtoreg = 2'd1;
         end
         OP_SW: begin
            dec_p0.regwen  = 1'b0;
            dec_p0.alusrc  = 1'b1;
            dec_p0.aluop   = ALU_ADD;
            dec_p0.dmemwen = 1'b1;
            rt_used_p0     = 1'b1;
         end
         // SC writes its success flag back to rt through the memory path.
         OP_SC: begin
            dec_p0.alusrc   = 1'b1;
            dec_p0.aluop    = ALU_ADD;
            dec_p0.dmemwen  = 1'b1;
            dec_p0.memtoreg = 2'd1;
         end
         OP_HALT: begin
            dec_p0.regwen = 1'b0;
            rs_used_p0    = 1'b0;
            is_halt_p0    = 1'b1;
         end
         default: ;
      endcase
   end

   // ---- stage p1: ID/EX control register and halt FSM ----
   ctrl_t      idex_p1;
   state_t     state, state_n;
   logic [3:0] drain_cnt, drain_cnt_n;
   logic       load_p1;
   ctrl_t      load_val_p1;
   logic       stall_c;
   logic       hazard_p0;

   assign hazard_p0 = HAZARD_EN && idex_p1.valid && idex_p1.dmemren &&
                      (idex_p1.wsel != '0) && instr_valid &&
                      ((rs_used_p0 && (idex_p1.wsel == rs_idx)) ||
                       (rt_used_p0 && (idex_p1.wsel == rt_idx)));

   always_comb begin
      state_n     = state;
      drain_cnt_n = drain_cnt;
      load_p1     = 1'b0;
      load_val_p1 = bubble_ctrl();
      stall_c     = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_busy) begin
               stall_c = 1'b1;
            end else if (flush) begin
               load_p1 = 1'b1;
            end else if (hazard_p0) begin
               load_p1 = 1'b1;
               stall_c = 1'b1;
            end else begin
               load_p1 = 1'b1;
               if (instr_valid) begin
                  load_val_p1 = dec_p0;
                  if (is_halt_p0) begin
                     state_n     = ST_DRAIN;
                     drain_cnt_n = '0;
                  end
               end
            end
         end
         ST_DRAIN: begin
            stall_c = 1'b1;
            if (!mem_busy) begin
               load_p1 = 1'b1;
               // A flush means the HALT was on the wrong path; the PC must be
               // free to take the redirect, so the stall is released too.
               if (flush) begin
                  state_n     = ST_RUN;
                  drain_cnt_n = '0;
                  stall_c     = 1'b0;
               end else if (drain_cnt == DRAIN_LAST) begin
                  state_n = ST_HALTED;
               end else begin
                  drain_cnt_n = drain_cnt + 4'd1;
               end
            end
         end
         ST_HALTED: begin
            stall_c = 1'b1;
            load_p1 = !mem_busy;
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         idex_p1   <= bubble_ctrl();
      end else begin
         state     <= state_n;
         drain_cnt <= drain_cnt_n;
         if (load_p1) idex_p1 <= load_val_p1;
      end
   end

   // stall is forced low while reset is held, whatever mem_busy does.
   assign stall       = nRST & stall_c;
   assign halt        = (state == ST_HALTED);
   assign ex_valid    = idex_p1.valid;
   assign ex_regwen   = idex_p1.regwen;
   assign ex_dmemren  = idex_p1.dmemren;
   assign ex_dmemwen  = idex_p1.dmemwen;
   assign ex_alusrc   = idex_p1.alusrc;
   assign ex_extop    = idex_p1.extop;
   assign ex_aluop    = idex_p1.aluop;
   assign ex_memtoreg = idex_p1.memtoreg;
   assign ex_pcsel    = idex_p1.pcsel;
   assign ex_beq      = idex_p1.beq;
   assign ex_wsel     = idex_p1.wsel;
   assign ex_rs       = idex_p1.rs;
   assign ex_rt       = idex_p1.rt;

endmodule
